// File: rtl/sparc_mem_pkg.sv
// rtl/sparc_mem_pkg.sv - shared encodings and request record for the memory responder
package sparc_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    typedef struct packed {
        logic        rw;
        logic [1:0]  size;
        logic        sign_ext;
        logic [31:0] data;
    } req_t;

    // Size 11 falls into the default branch and is checked like a word.
    function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            SIZE_BYTE: return 1'b1;
            SIZE_HALF: return ~a[0];
            default:   return (a == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_array.sv
// rtl/mem_byte_array.sv - byte RAM, sync write / async read, four wrapping byte lanes
module mem_byte_array #(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [3:0]            wr_en,
    input  logic [31:0]           wr_data,
    output logic [31:0]           rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [7:0]            mem [DEPTH];
    logic [ADDR_WIDTH-1:0] lane_addr [4];

    // Lane i is byte addr+i; lane 0 sits in the most significant byte.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign lane_addr[i]          = addr + ADDR_WIDTH'(i);
        assign rd_data[31-8*i -: 8]  = mem[lane_addr[i]];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en[i]) begin
                mem[lane_addr[i]] <= wr_data[31-8*i -: 8];
            end
        end
    end

endmodule

// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - MOV/MOC memory responder with wait states and big-endian access
module memory_responder
    import sparc_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        MOV,
    input  logic        RW,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        MOC,
    output logic        misaligned
);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    req_t                  req_q, req_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [31:0]           data_out_q, data_out_d;
    logic                  moc_q, moc_d;
    logic                  mis_q, mis_d;

    logic [3:0]  wr_en, lane_en;
    logic [31:0] wr_data, lane_data, rd_data, ext_data;
    logic        aligned;

    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[31:ADDR_WIDTH];

    mem_byte_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk     (clk),
        .addr    (req_addr_q),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            req_q      <= '0;
            req_addr_q <= '0;
            data_out_q <= '0;
            moc_q      <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            req_addr_q <= req_addr_d;
            data_out_q <= data_out_d;
            moc_q      <= moc_d;
            mis_q      <= mis_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (MOV) state_d = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
            S_WAIT:   if (cnt_q <= 4'd1) state_d = S_ACCESS;
            S_ACCESS: state_d = S_DONE;
            S_DONE:   if (!MOV) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Big-endian lane mapping: the addressed byte is lane 0 (MSB of the word).
    always_comb begin
        lane_en   = 4'b1111;
        lane_data = req_q.data;
        ext_data  = rd_data;
        case (req_q.size)
            SIZE_BYTE: begin
                lane_en   = 4'b0001;
                lane_data = {req_q.data[7:0], 24'd0};
                ext_data  = {{24{req_q.sign_ext & rd_data[31]}}, rd_data[31:24]};
            end
            SIZE_HALF: begin
                lane_en   = 4'b0011;
                lane_data = {req_q.data[15:0], 16'd0};
                ext_data  = {{16{req_q.sign_ext & rd_data[31]}}, rd_data[31:16]};
            end
            default: ;
        endcase
    end

    assign aligned = is_aligned(req_q.size, req_addr_q[1:0]);

    always_comb begin
        cnt_d      = cnt_q;
        req_d      = req_q;
        req_addr_d = req_addr_q;
        data_out_d = data_out_q;
        moc_d      = moc_q;
        mis_d      = mis_q;
        wr_en      = '0;
        wr_data    = '0;
        case (state_q)
            S_IDLE: begin
                if (MOV) begin
                    cnt_d      = 4'(WAIT_CYCLES);
                    req_d      = '{rw: RW, size: size, sign_ext: sign_ext, data: data_in};
                    req_addr_d = addr[ADDR_WIDTH-1:0];
                end
            end
            S_WAIT: cnt_d = cnt_q - 4'd1;
            S_ACCESS: begin
                moc_d = 1'b1;
                mis_d = ~aligned;
                if (!aligned) begin
                    data_out_d = '0;
                end else if (req_q.rw == RW_READ) begin
                    data_out_d = ext_data;
                end else begin
                    wr_en   = lane_en;
                    wr_data = lane_data;
                end
            end
            S_DONE: if (!MOV) moc_d = 1'b0;
            default: ;
        endcase
    end

    assign data_out   = data_out_q;
    assign MOC        = moc_q;
    assign misaligned = mis_q;

endmodule

// File: tb/tb_memory_responder.sv
// tb/tb_memory_responder.sv - directed self-checking bench for memory_responder
module tb_memory_responder;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        mov0 = 1'b0, mov1 = 1'b0;
    logic        rw = 1'b1;
    logic [1:0]  sz = 2'b00;
    logic        sext = 1'b0;
    logic [31:0] addr = '0, din = '0;
    logic [31:0] dout0, dout1;
    logic        moc0, moc1, mis0, mis1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    memory_responder u_dut0 (
        .clk(clk), .clr(clr), .MOV(mov0), .RW(rw), .size(sz), .sign_ext(sext),
        .addr(addr), .data_in(din), .data_out(dout0), .MOC(moc0), .misaligned(mis0)
    );

    memory_responder #(.ADDR_WIDTH(9), .WAIT_CYCLES(0)) u_dut1 (
        .clk(clk), .clr(clr), .MOV(mov1), .RW(rw), .size(sz), .sign_ext(sext),
        .addr(addr), .data_in(din), .data_out(dout1), .MOC(moc1), .misaligned(mis1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic cur_moc(input int inst);
        return (inst == 0) ? moc0 : moc1;
    endfunction

    task automatic set_mov(input int inst, input logic v);
        if (inst == 0) mov0 = v;
        else mov1 = v;
    endtask

    // Present a request, wait (bounded) for MOC and report edges after the sampling edge.
    task automatic req(input int inst, input logic r, input logic [1:0] s, input logic se,
                       input logic [31:0] a, input logic [31:0] d, output int lat);
        @(negedge clk);
        rw = r; sz = s; sext = se; addr = a; din = d;
        set_mov(inst, 1'b1);
        @(posedge clk);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!cur_moc(inst) && lat < 20);
    endtask

    task automatic drop(input int inst);
        @(negedge clk);
        set_mov(inst, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic xfer(input string tag, input int inst, input logic r, input logic [1:0] s,
                        input logic se, input logic [31:0] a, input logic [31:0] d,
                        input int exp_lat, input logic [31:0] exp_dout, input logic exp_mis);
        int lat;
        req(inst, r, s, se, a, d, lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_dout"}, (inst == 0) ? dout0 : dout1, exp_dout);
        check({tag, "_mis"}, {31'd0, (inst == 0) ? mis0 : mis1}, {31'd0, exp_mis});
        drop(inst);
    endtask

    initial begin
        int lat, high;

        repeat (3) @(posedge clk);
        #1;
        check("rst_moc", {31'd0, moc0}, 32'd0);
        check("rst_dout", dout0, 32'd0);
        check("rst_mis", {31'd0, mis0}, 32'd0);
        @(negedge clk); clr = 1'b1;

        // Reset in the middle of a write's wait states
        xfer("w010", 0, 1'b0, 2'b10, 1'b0, 32'h010, 32'hA5A5_A5A5, 3, 32'h0, 1'b0);
        xfer("r010", 0, 1'b1, 2'b10, 1'b0, 32'h010, 32'h0, 3, 32'hA5A5_A5A5, 1'b0);
        @(negedge clk);
        rw = 1'b0; sz = 2'b10; addr = 32'h010; din = 32'h1234_5678; mov0 = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0; mov0 = 1'b0;
        #1;
        check("rstw_moc", {31'd0, moc0}, 32'd0);
        check("rstw_dout", dout0, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); clr = 1'b1;
        xfer("r010b", 0, 1'b1, 2'b10, 1'b0, 32'h010, 32'h0, 3, 32'hA5A5_A5A5, 1'b0);

        // Word write/read and big-endian byte order
        xfer("w020", 0, 1'b0, 2'b10, 1'b0, 32'h020, 32'hDEAD_BEEF, 3, 32'hA5A5_A5A5, 1'b0);
        xfer("r020", 0, 1'b1, 2'b10, 1'b0, 32'h020, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);
        xfer("rb020", 0, 1'b1, 2'b00, 1'b0, 32'h020, 32'h0, 3, 32'h0000_00DE, 1'b0);

        // Extension
        xfer("rb021s", 0, 1'b1, 2'b00, 1'b1, 32'h021, 32'h0, 3, 32'hFFFF_FFAD, 1'b0);
        xfer("rh022z", 0, 1'b1, 2'b01, 1'b0, 32'h022, 32'h0, 3, 32'h0000_BEEF, 1'b0);
        xfer("rh022s", 0, 1'b1, 2'b01, 1'b1, 32'h022, 32'h0, 3, 32'hFFFF_BEEF, 1'b0);
        xfer("r020sz3", 0, 1'b1, 2'b11, 1'b0, 32'h020, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);

        // Misalignment
        xfer("rw022", 0, 1'b1, 2'b10, 1'b0, 32'h022, 32'h0, 3, 32'h0, 1'b1);
        xfer("wh023", 0, 1'b0, 2'b01, 1'b0, 32'h023, 32'h0000_1234, 3, 32'h0, 1'b1);
        xfer("r020c", 0, 1'b1, 2'b10, 1'b0, 32'h020, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);

        // MOC held while MOV stays high, released one edge after MOV drops
        req(0, 1'b1, 2'b00, 1'b0, 32'h023, 32'h0, lat);
        check("hold_lat", lat, 3);
        high = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (moc0) high++;
        end
        check("hold_moc", high, 5);
        check("hold_dout", dout0, 32'h0000_00EF);
        drop(0);
        check("drop_moc", {31'd0, moc0}, 32'd0);

        // MOV dropped during wait: exactly one MOC cycle
        @(negedge clk);
        rw = 1'b1; sz = 2'b10; sext = 1'b0; addr = 32'h010; mov0 = 1'b1;
        @(posedge clk);
        @(negedge clk); mov0 = 1'b0;
        high = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (moc0) high++;
        end
        check("early_pulse", high, 1);
        check("early_dout", dout0, 32'hA5A5_A5A5);

        // Zero wait states, top of memory
        xfer("z_w1fc", 1, 1'b0, 2'b10, 1'b0, 32'h1FC, 32'h1122_3344, 1, 32'h0, 1'b0);
        xfer("z_rb1ff", 1, 1'b1, 2'b00, 1'b0, 32'h1FF, 32'h0, 1, 32'h0000_0044, 1'b0);
        xfer("z_rh1fe", 1, 1'b1, 2'b01, 1'b1, 32'h1FE, 32'h0, 1, 32'h0000_3344, 1'b0);
        xfer("z_rw1fc", 1, 1'b1, 2'b10, 1'b0, 32'hFFFF_F1FC, 32'h0, 1, 32'h1122_3344, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
